// File: rtl/keccak_squeeze_gearbox.sv
// Squeeze-side width converter: splits wide digest beats into OUT_DWIDTH words, LSB word first.
// Define KECCAK_GEARBOX_SKID_EN to add a one-beat skid register for gapless output across beats.
module keccak_squeeze_gearbox #(
    parameter int IN_DWIDTH  = 256,
    parameter int OUT_DWIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic [IN_DWIDTH-1:0]    s_data_i,
    input  logic [IN_DWIDTH/8-1:0]  s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [OUT_DWIDTH-1:0]   m_data_o,
    output logic [OUT_DWIDTH/8-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    busy_o
);
    localparam int IN_KEEP  = IN_DWIDTH / 8;
    localparam int OUT_KEEP = OUT_DWIDTH / 8;
    localparam int RATIO    = IN_DWIDTH / OUT_DWIDTH;
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int NW_W     = $clog2(RATIO + 1);

    typedef enum logic {EMPTY, DRAIN} state_t;

    state_t               state;
    logic [IN_DWIDTH-1:0] buf_data;
    logic [IN_KEEP-1:0]   buf_keep;
    logic                 buf_last;
    logic [IDX_W-1:0]     idx;
    logic [NW_W-1:0]      n_words;

    logic                 in_hs, in_load, out_hs, last_word, freeing;
    logic [IN_DWIDTH-1:0] ld_data;
    logic [IN_KEEP-1:0]   ld_keep;
    logic                 ld_last, ld_valid;

    // A keep-less beat still yields one word so that a bare last can be forwarded.
    function automatic logic [NW_W-1:0] calc_words(input logic [IN_KEEP-1:0] keep);
        logic [NW_W-1:0] n;
        n = NW_W'(1);
        for (int w = 0; w < RATIO; w++)
            if (|keep[w*OUT_KEEP +: OUT_KEEP]) n = NW_W'(w + 1);
        return n;
    endfunction

    assign in_hs     = s_valid_i && s_ready_o;
    assign in_load   = in_hs && (s_last_i || (|s_keep_i));
    assign out_hs    = m_valid_o && m_ready_i;
    assign last_word = (NW_W'(idx) == n_words - NW_W'(1));
    assign freeing   = (state == EMPTY) || (out_hs && last_word);

    assign m_valid_o = (state == DRAIN) && !flush_i;
    assign m_data_o  = buf_data[OUT_DWIDTH*int'(idx) +: OUT_DWIDTH];
    assign m_keep_o  = buf_keep[OUT_KEEP*int'(idx) +: OUT_KEEP];
    assign m_last_o  = buf_last && last_word;

`ifdef KECCAK_GEARBOX_SKID_EN
    logic                 skid_valid;
    logic [IN_DWIDTH-1:0] skid_data;
    logic [IN_KEEP-1:0]   skid_keep;
    logic                 skid_last;

    // The skid can only be full while the main buffer is draining, so it always wins the reload.
    assign s_ready_o = !skid_valid && !flush_i;
    assign busy_o    = (state == DRAIN) || skid_valid;
    assign ld_data   = skid_valid ? skid_data : s_data_i;
    assign ld_keep   = skid_valid ? skid_keep : s_keep_i;
    assign ld_last   = skid_valid ? skid_last : s_last_i;
    assign ld_valid  = skid_valid || in_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
        end else if (flush_i) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
        end else if (skid_valid && freeing) begin
            skid_valid <= 1'b0;
        end else if (in_load && !freeing) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data_i;
            skid_keep  <= s_keep_i;
            skid_last  <= s_last_i;
        end
    end
`else
    assign s_ready_o = (state == EMPTY) && !flush_i;
    assign busy_o    = (state == DRAIN);
    assign ld_data   = s_data_i;
    assign ld_keep   = s_keep_i;
    assign ld_last   = s_last_i;
    assign ld_valid  = in_load;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            buf_data <= '0;
            buf_keep <= '0;
            buf_last <= 1'b0;
            idx      <= '0;
            n_words  <= NW_W'(1);
        end else if (flush_i) begin
            state    <= EMPTY;
            buf_data <= '0;
            buf_keep <= '0;
            buf_last <= 1'b0;
            idx      <= '0;
            n_words  <= NW_W'(1);
        end else begin
            if (state == DRAIN && out_hs && !last_word)
                idx <= idx + 1'b1;
            if (freeing) begin
                if (ld_valid) begin
                    state    <= DRAIN;
                    buf_data <= ld_data;
                    buf_keep <= ld_keep;
                    buf_last <= ld_last;
                    idx      <= '0;
                    n_words  <= calc_words(ld_keep);
                end else begin
                    state    <= EMPTY;
                end
            end
        end
    end
endmodule
